// File: rtl/processor_dp.sv
// ---------------------------------------------------------------------------
// processor_dp
//
// Datapath for a small accumulator machine. The control unit drives every
// load/select strobe; this block has no sequencer of its own. The only state
// that changes without a strobe is the memory data register (MDR), which
// samples the RAM word at the selected address on every rising edge.
//
// Storage
//   PC   : ADDR_W-bit program counter
//   IR   : DATA_W-bit instruction register (opcode in the top bits,
//          operand address in the low ADDR_W bits)
//   A    : DATA_W-bit accumulator
//   MDR  : DATA_W-bit registered RAM read data
//   RAM  : 2**ADDR_W x DATA_W unified program/data memory (never reset)
//
// Ports
//   Clock     in   single clock, every register updates on its rising edge
//   Reset_n   in   asynchronous active-low reset of PC, IR, A and MDR
//   IRload    in   IR <= MDR
//   JMPmux    in   PC source: 0 = PC+1, 1 = IR operand address
//   PCload    in   PC <= JMPmux-selected source
//   Meminst   in   RAM address: 0 = PC, 1 = IR operand address
//   MemWr     in   RAM[address] <= A
//   Aload     in   A <= Asel-selected source
//   Sub       in   ALU: 0 = A + MDR, 1 = A - MDR (modulo 2**DATA_W)
//   Asel      in   A source: 00 ALU, 01 Input, 10/11 MDR
//   Input     in   external data for the IN instruction
//   ProgWr    in   program-load strobe, RAM[ProgAddr] <= ProgData
//   ProgAddr  in   program-load address
//   ProgData  in   program-load data
//   IR        out  opcode field of the instruction register
//   Aeq0      out  A is zero
//   Apos      out  A is strictly positive as a signed value
//   Output    out  current accumulator value
//   PC        out  current program counter
// ---------------------------------------------------------------------------
module processor_dp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       IRload,
    input  logic                       JMPmux,
    input  logic                       PCload,
    input  logic                       Meminst,
    input  logic                       MemWr,
    input  logic                       Aload,
    input  logic                       Sub,
    input  logic [1:0]                 Asel,
    input  logic [DATA_W-1:0]          Input,
    input  logic                       ProgWr,
    input  logic [ADDR_W-1:0]          ProgAddr,
    input  logic [DATA_W-1:0]          ProgData,
    output logic [DATA_W-ADDR_W-1:0]   IR,
    output logic                       Aeq0,
    output logic                       Apos,
    output logic [DATA_W-1:0]          Output,
    output logic [ADDR_W-1:0]          PC
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Architectural registers
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] mdr_reg;

    // Unified program/data memory
    logic [DATA_W-1:0] mem [DEPTH];

    // Combinational datapath nets
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] a_next;
    logic              cpu_enable;

    // Operand address field of the instruction register. Jumps and
    // memory-operand instructions both take their target from here.
    assign ir_addr = ir_reg[ADDR_W-1:0];

    // Instruction fetches come from PC, operand accesses from the IR field.
    assign mem_addr = Meminst ? ir_addr : pc_reg;

    // A program load freezes the architectural registers, so a boot loader
    // can stream a program in without having to idle the control unit.
    assign cpu_enable = ~ProgWr;

    // Next PC: sequential increment wraps naturally at the top of memory.
    always_comb begin
        pc_next = pc_reg + ADDR_W'(1);
        if (JMPmux) begin
            pc_next = ir_addr;
        end
    end

    // Add/subtract unit. Carry and borrow are discarded, so results wrap
    // modulo 2**DATA_W.
    always_comb begin
        alu_result = a_reg + mdr_reg;
        if (Sub) begin
            alu_result = a_reg - mdr_reg;
        end
    end

    // Accumulator source mux. Both upper Asel codes select MDR so the LOAD
    // instruction does not care about the low select bit.
    always_comb begin
        a_next = mdr_reg;
        unique case (Asel)
            2'b00:   a_next = alu_result;
            2'b01:   a_next = Input;
            default: a_next = mdr_reg;
        endcase
    end

    // Memory array write port. Program loading wins over a store from the
    // datapath; a store issued in the same cycle is simply lost.
    always_ff @(posedge Clock) begin
        if (ProgWr) begin
            mem[ProgAddr] <= ProgData;
        end else if (MemWr) begin
            mem[mem_addr] <= a_reg;
        end
    end

    // Registered memory read. Because the array update above is also
    // non-blocking, a read of the address being written returns the word
    // that was there before the edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mdr_reg <= '0;
        end else begin
            mdr_reg <= mem[mem_addr];
        end
    end

    // Instruction register. During a fetch the PC update below uses the
    // pre-edge IR, so IRload and PCload may be asserted together.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_reg <= '0;
        end else if (cpu_enable && IRload) begin
            ir_reg <= mdr_reg;
        end
    end

    // Program counter. JMPmux only matters when PCload is asserted.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_reg <= '0;
        end else if (cpu_enable && PCload) begin
            pc_reg <= pc_next;
        end
    end

    // Accumulator. Holding Aload with Asel=01 keeps resampling Input,
    // which is how the IN instruction waits for the user.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg <= '0;
        end else if (cpu_enable && Aload) begin
            a_reg <= a_next;
        end
    end

    // Branch flags come from the committed accumulator, not the ALU output,
    // so they describe A as the control unit sees it in the current state.
    assign Aeq0   = (a_reg == '0);
    assign Apos   = ~a_reg[DATA_W-1] & (a_reg != '0);

    assign IR     = ir_reg[DATA_W-1:ADDR_W];
    assign Output = a_reg;
    assign PC     = pc_reg;

endmodule

// File: tb/tb_processor_dp.sv
// ---------------------------------------------------------------------------
// tb_processor_dp
//
// Self-checking bench for processor_dp. Directed instruction sequences are
// followed by a randomized run; every clocked step is compared with a
// reference model that tracks the machine as plain integers and an integer
// array standing in for the RAM.
// ---------------------------------------------------------------------------
module tb_processor_dp;

    logic       Clock;
    logic       Reset_n;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic       Sub;
    logic [1:0] Asel;
    logic [7:0] Input;
    logic       ProgWr;
    logic [4:0] ProgAddr;
    logic [7:0] ProgData;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic [7:0] Output;
    logic [4:0] PC;

    // Reference machine state
    int m_pc;
    int m_ir;
    int m_a;
    int m_mdr;
    int m_mem [32];

    int    tests;
    int    fails;
    string curTag;
    int    savedWord;

    processor_dp #(.DATA_W(8), .ADDR_W(5)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .IRload   (IRload),
        .JMPmux   (JMPmux),
        .PCload   (PCload),
        .Meminst  (Meminst),
        .MemWr    (MemWr),
        .Aload    (Aload),
        .Sub      (Sub),
        .Asel     (Asel),
        .Input    (Input),
        .ProgWr   (ProgWr),
        .ProgAddr (ProgAddr),
        .ProgData (ProgData),
        .IR       (IR),
        .Aeq0     (Aeq0),
        .Apos     (Apos),
        .Output   (Output),
        .PC       (PC)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // One comparison: counts it, and on a mismatch counts and reports it.
    task automatic checkValue(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compares every DUT output with what the reference machine implies.
    // Signed positivity is computed by reinterpreting A as -128..127.
    task automatic checkOutput(input string tag);
        int signedA;
        signedA = (m_a > 127) ? m_a - 256 : m_a;
        checkValue({tag, ".IR"},     int'(IR),     m_ir / 32);
        checkValue({tag, ".PC"},     int'(PC),     m_pc);
        checkValue({tag, ".Output"}, int'(Output), m_a);
        checkValue({tag, ".Aeq0"},   int'(Aeq0),   (m_a == 0) ? 1 : 0);
        checkValue({tag, ".Apos"},   int'(Apos),   (signedA > 0) ? 1 : 0);
    endtask

    task automatic modelReset();
        m_pc  = 0;
        m_ir  = 0;
        m_a   = 0;
        m_mdr = 0;
    endtask

    // Deasserts every control strobe.
    task automatic idle();
        IRload   = 1'b0;
        JMPmux   = 1'b0;
        PCload   = 1'b0;
        Meminst  = 1'b0;
        MemWr    = 1'b0;
        Aload    = 1'b0;
        Sub      = 1'b0;
        Asel     = 2'b00;
        ProgWr   = 1'b0;
        ProgAddr = 5'd0;
        ProgData = 8'd0;
    endtask

    // Runs one clock with the currently driven controls. The next machine
    // state is worked out from the current one before the edge, committed
    // at the edge, and compared with the DUT on the following falling edge.
    task automatic applyStimulus();
        int addr;
        int nPc;
        int nIr;
        int nA;
        int nMdr;
        addr = Meminst ? (m_ir % 32) : m_pc;
        nMdr = m_mem[addr];
        nPc  = m_pc;
        nIr  = m_ir;
        nA   = m_a;
        if (!ProgWr) begin
            if (IRload) nIr = m_mdr;
            if (PCload) nPc = JMPmux ? (m_ir % 32) : (m_pc + 1) % 32;
            if (Aload) begin
                if (Asel == 2'b00)
                    nA = Sub ? (m_a - m_mdr + 256) % 256 : (m_a + m_mdr) % 256;
                else if (Asel == 2'b01)
                    nA = int'(Input);
                else
                    nA = m_mdr;
            end
        end
        @(posedge Clock);
        if (ProgWr)
            m_mem[ProgAddr] = int'(ProgData);
        else if (MemWr)
            m_mem[addr] = m_a;
        m_pc  = nPc;
        m_ir  = nIr;
        m_a   = nA;
        m_mdr = nMdr;
        @(negedge Clock);
        checkOutput(curTag);
    endtask

    task automatic progWrite(input int addr, input int data);
        idle();
        ProgWr   = 1'b1;
        ProgAddr = 5'(addr);
        ProgData = 8'(data);
        applyStimulus();
        idle();
    endtask

    task automatic loadA(input int value);
        idle();
        Asel  = 2'b01;
        Aload = 1'b1;
        Input = 8'(value);
        applyStimulus();
        idle();
    endtask

    // Places a word at the current PC and pulls it into IR via MDR.
    task automatic setIR(input int value);
        progWrite(m_pc, value);
        applyStimulus();
        IRload = 1'b1;
        applyStimulus();
        idle();
    endtask

    task automatic setPC(input int value);
        setIR(value);
        JMPmux = 1'b1;
        PCload = 1'b1;
        applyStimulus();
        idle();
    endtask

    // Reads a RAM word into A through an operand access.
    task automatic readRam(input int addr);
        setIR(addr);
        Meminst = 1'b1;
        applyStimulus();
        idle();
        Asel  = 2'b10;
        Aload = 1'b1;
        applyStimulus();
        idle();
    endtask

    // Directed sequences followed by a randomized run.
    initial begin
        tests   = 0;
        fails   = 0;
        curTag  = "init";
        Input   = 8'd0;
        Reset_n = 1'b0;
        idle();
        modelReset();
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
        @(negedge Clock);
        checkOutput("reset0");
        Reset_n = 1'b1;

        // Give every RAM word a known value
        curTag = "fill";
        for (int i = 0; i < 32; i++) progWrite(i, int'($urandom_range(0, 255)));

        // Asynchronous reset mid-cycle with an accumulator load pending
        curTag = "presetup";
        progWrite(3, 8'hA5);
        loadA(8'h55);
        setPC(7);
        checkValue("pre_reset.PC", int'(PC), 7);
        checkValue("pre_reset.A", int'(Output), 8'h55);
        Asel  = 2'b01;
        Aload = 1'b1;
        Input = 8'h99;
        #2;
        Reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_async");
        checkValue("reset.A", int'(Output), 0);
        checkValue("reset.PC", int'(PC), 0);
        @(negedge Clock);
        checkOutput("reset_held");
        idle();
        Reset_n = 1'b1;
        curTag = "ramkeep";
        readRam(3);
        checkValue("ram_survives_reset", int'(Output), 8'hA5);

        // Start / fetch / decode / load
        curTag = "fetch";
        progWrite(0, 8'h05);
        progWrite(5, 8'h7F);
        applyStimulus();
        IRload = 1'b1;
        PCload = 1'b1;
        applyStimulus();
        idle();
        checkValue("fetch.IR", int'(IR), 0);
        checkValue("fetch.PC", int'(PC), 1);
        Meminst = 1'b1;
        applyStimulus();
        idle();
        Asel  = 2'b10;
        Aload = 1'b1;
        applyStimulus();
        idle();
        checkValue("load.A", int'(Output), 8'h7F);
        checkValue("load.Apos", int'(Apos), 1);
        checkValue("load.Aeq0", int'(Aeq0), 0);

        // Add and subtract wrap-around
        curTag = "alu";
        loadA(8'hF0);
        progWrite(6, 8'h20);
        setIR(6);
        Meminst = 1'b1;
        applyStimulus();
        Aload = 1'b1;
        applyStimulus();
        idle();
        checkValue("add_wrap.A", int'(Output), 8'h10);
        checkValue("add_wrap.Apos", int'(Apos), 1);
        progWrite(6, 8'h10);
        Meminst = 1'b1;
        applyStimulus();
        Aload = 1'b1;
        Sub   = 1'b1;
        applyStimulus();
        idle();
        checkValue("sub_zero.A", int'(Output), 0);
        checkValue("sub_zero.Aeq0", int'(Aeq0), 1);
        progWrite(6, 8'h01);
        Meminst = 1'b1;
        applyStimulus();
        Aload = 1'b1;
        Sub   = 1'b1;
        applyStimulus();
        idle();
        checkValue("sub_borrow.A", int'(Output), 8'hFF);
        checkValue("sub_borrow.Apos", int'(Apos), 0);
        checkValue("sub_borrow.Aeq0", int'(Aeq0), 0);

        // Store, then read-during-write and the following read
        curTag = "store";
        progWrite(9, 8'h11);
        loadA(8'h3C);
        setIR(8'h29);
        checkValue("store.IRop", int'(IR), 1);
        Meminst = 1'b1;
        MemWr   = 1'b1;
        applyStimulus();
        idle();
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
        applyStimulus();
        checkValue("store.old_mdr", int'(Output), 8'h11);
        applyStimulus();
        idle();
        checkValue("store.new_mdr", int'(Output), 8'h3C);

        // Jumps and PC wrap
        curTag = "jump";
        loadA(0);
        setIR(8'hB4);
        checkValue("jump.IRop", int'(IR), 5);
        JMPmux = 1'b1;
        PCload = 1'b1;
        applyStimulus();
        idle();
        checkValue("jump.PC", int'(PC), 8'h14);
        setPC(31);
        checkValue("jump31.PC", int'(PC), 31);
        PCload = 1'b1;
        applyStimulus();
        idle();
        checkValue("pc_wrap.PC", int'(PC), 0);
        JMPmux = 1'b1;
        applyStimulus();
        idle();
        checkValue("jmpmux_noload.PC", int'(PC), 0);

        // IN instruction, held for two cycles
        curTag = "input";
        Asel  = 2'b01;
        Aload = 1'b1;
        Input = 8'h81;
        applyStimulus();
        checkValue("in.A", int'(Output), 8'h81);
        checkValue("in.Apos", int'(Apos), 0);
        Input = 8'h02;
        applyStimulus();
        idle();
        checkValue("in_repeat.A", int'(Output), 8'h02);

        // Program write has priority and freezes PC, IR and A
        curTag = "progprio";
        savedWord = m_mem[31];
        ProgWr   = 1'b1;
        ProgAddr = 5'd10;
        ProgData = 8'h5A;
        MemWr    = 1'b1;
        Meminst  = 1'b1;
        IRload   = 1'b1;
        PCload   = 1'b1;
        Aload    = 1'b1;
        Asel     = 2'b01;
        Input    = 8'h77;
        applyStimulus();
        idle();
        checkValue("prio.PC", int'(PC), 0);
        checkValue("prio.A", int'(Output), 8'h02);
        readRam(10);
        checkValue("prio.ram10", int'(Output), 8'h5A);
        readRam(31);
        checkValue("prio.ram31", int'(Output), savedWord);

        // Randomized control sequences against the reference machine
        curTag = "rand";
        for (int n = 0; n < 400; n++) begin
            idle();
            IRload  = 1'($urandom_range(0, 1));
            JMPmux  = 1'($urandom_range(0, 1));
            PCload  = 1'($urandom_range(0, 1));
            Meminst = 1'($urandom_range(0, 1));
            MemWr   = ($urandom_range(0, 3) == 0);
            Aload   = 1'($urandom_range(0, 1));
            Sub     = 1'($urandom_range(0, 1));
            Asel    = 2'($urandom_range(0, 3));
            Input   = 8'($urandom_range(0, 255));
            ProgWr  = ($urandom_range(0, 7) == 0);
            ProgAddr = 5'($urandom_range(0, 31));
            ProgData = 8'($urandom_range(0, 255));
            applyStimulus();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/processor_dp.md
Name: processor_dp

Overview:
- Datapath consumed by the processor control unit. Takes its status signals and returns IR opcode bits plus the Aeq0/Apos flags.
- Holds:
  - PC (5b)
  - IR (8b)
  - 32x8 unified program/data RAM with registered read (MDR)
  - accumulator A (8b)
  - add/sub unit
  - A-input and address muxes
- Provides a bench/boot program-write port.

Parameters:
- DATA_W, 8, word width of A, IR, MDR, RAM.
- ADDR_W, 5, PC and RAM address width (RAM depth 2**ADDR_W); opcode = IR[DATA_W-1:ADDR_W].

Ports:
- Clock  in  1  single clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- IRload  in  1  load IR from MDR.
- JMPmux  in  1  PC source: 0 = PC+1, 1 = IR[4:0].
- PCload  in  1  load PC from JMPmux-selected source.
- Meminst  in  1  RAM address: 0 = PC, 1 = IR[4:0].
- MemWr  in  1  write A to RAM at selected address.
- Aload  in  1  load A from Asel-selected source.
- Sub  in  1  ALU op: 0 = A+MDR, 1 = A-MDR.
- Asel  in  2  A source: 00 ALU, 01 Input, 10 MDR, 11 MDR.
- Input  in  8  external data for IN instruction.
- ProgWr  in  1  program-load write strobe.
- ProgAddr  in  5  program-load address.
- ProgData  in  8  program-load data.
- IR  out  3  opcode IR[7:5] to control unit.
- Aeq0  out  1  A == 0.
- Apos  out  1  A signed > 0.
- Output  out  8  current A.
- PC  out  5  current PC (debug).

Behaviour:
- Reset (Reset_n=0, async):
  - PC=0, IR=0, A=0, MDR=0, so IR out=000, Aeq0=1, Apos=0, Output=0.
  - RAM contents not cleared.
  - A mid-instruction reset discards all in-flight register updates immediately.
- Address mux (combinational): addr = Meminst ? IR[4:0] : PC.
- MDR: every rising edge MDR <= RAM[addr] (1-cycle read latency). Read-during-write to the same address returns OLD data.
- RAM write on rising edge:
  - ProgWr=1: RAM[ProgAddr] <= ProgData.
  - Else MemWr=1: RAM[addr] <= A.
  - ProgWr has priority; a concurrent MemWr is dropped.
  - While ProgWr=1, PC, IR and A hold regardless of other controls. MDR still updates from addr.
- IR: IRload=1 gives IR <= MDR.
- PC:
  - PCload=1 gives PC <= (JMPmux ? IR[4:0] : PC+1).
  - PC+1 wraps 31 -> 0.
  - JMPmux has no effect when PCload=0.
- A: Aload=1 gives A <= mux(Asel). ALU is 8-bit two's complement modulo 256: A+MDR or A-MDR, carry/borrow discarded.
- Flags are combinational from the A register only, not from the ALU result:
  - Aeq0 = (A==0).
  - Apos = ~A[7] & (A!=0).
- Simultaneous IRload and PCload (fetch): both use pre-edge values. IR <= MDR, PC <= PC+1 (or IR[4:0] using OLD IR when JMPmux=1).
- Per-state sequencing the block must support (one cycle each):
  - start: Meminst=0, MDR <= RAM[PC].
  - fetch: IR <= MDR, PC++.
  - decode: Meminst=1, MDR <= RAM[IR[4:0]].
  - load: A <= MDR.
  - add/sub: A <= A±MDR.
  - store: RAM[IR[4:0]] <= A.
  - in: A <= Input, repeated while held.
  - jz/jpos: PC <= IR[4:0] when PCload asserted.
- No internal FSM; all sequencing comes from the control inputs. The MDR pipeline register is the only implicit state.

Test Plan:
- Reset: drive Reset_n low mid-cycle with A=0x55 and PC=7 -> immediately A=0, PC=0, Aeq0=1, Apos=0, IR=000. Preloaded RAM[3]=0xA5 reads back 0xA5 after reset.
- Fetch/decode/load: ProgWr RAM[0]=0x05 and RAM[5]=0x7F. Drive start, fetch, decode, load controls -> IR=000 after fetch, PC=1, A=0x7F after load, Apos=1, Aeq0=0.
- Add/sub wrap:
  - A=0xF0, RAM[6]=0x20, add sequence -> A=0x10, Apos=1.
  - Then sub with RAM[6]=0x10 -> A=0x00, Aeq0=1.
  - Then sub 0x01 -> A=0xFF, Apos=0, Aeq0=0.
- Store/readback: A=0x3C, IR=0x29 (store, addr 9), Meminst=1 and MemWr=1 one cycle -> RAM[9]=0x3C. Same-cycle MDR read of addr 9 returns old value; next read cycle MDR=0x3C.
- Jumps and PC wrap:
  - IR=0xB4, A=0, JMPmux=1, PCload=1 -> PC=0x14.
  - PC=31 with PCload=1, JMPmux=0 -> PC=0.
  - JMPmux=1 with PCload=0 -> PC unchanged.
- Input and ProgWr priority:
  - Asel=01, Aload=1, Input=0x81 -> A=0x81, Apos=0.
  - ProgWr=1 and MemWr=1 same edge to different addrs -> only ProgAddr written; PC, IR and A unchanged that cycle.
